outbuf_drain: RTL and testbench

- Reader at the far end of the output SRAM port that macarray writes with EN_O/RW_O/ADDR_O/WDATA_O.
- After a MAC run completes, it reads the packed result words back from the output SRAM and streams them to the host/DMA over a valid/ready interface.
- Sits beside macarray on the same output SRAM; an arbiter outside this block guarantees the two never drive the port in the same cycle.

---
 rtl/outbuf_drain_pkg.sv | 36 +++
 rtl/outbuf_drain_if.sv | 24 ++
 rtl/outbuf_fifo.sv | 53 +++++
 rtl/outbuf_drain.sv | 97 +++++++++
 tb/tb_outbuf_drain.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/outbuf_drain_pkg.sv
// Shared output-SRAM definitions: FSM encodings, MNT field layout, word geometry
// and the packed-result word count used by both the writer and the drain.
package outbuf_drain_pkg;

  localparam int DW  = 64;
  localparam int AW  = 4;
  localparam int EPW = 4;

  localparam int M_MSB = 11;
  localparam int M_LSB = 8;
  localparam int N_MSB = 7;
  localparam int N_LSB = 4;
  localparam int T_MSB = 3;
  localparam int T_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Words holding M*T 16-bit results, 4 per word; out-of-range dims saturate to a full SRAM.
  function automatic logic [7:0] word_count(input logic [11:0] mnt);
    logic [3:0] m;
    logic [3:0] t;
    logic [7:0] prod;
    m    = mnt[M_MSB:M_LSB];
    t    = mnt[T_MSB:T_LSB];
    prod = 8'(m) * 8'(t) + 8'(EPW - 1);
    if ((m > 4'd8) || (t > 4'd8))
      word_count = 8'd16;
    else
      word_count = prod >> $clog2(EPW);
  endfunction

endpackage

// File: rtl/outbuf_drain_if.sv
// Output-SRAM read port plus result stream; master is the drain, slave is SRAM/consumer side.
interface outbuf_drain_if #(
  parameter int DW = outbuf_drain_pkg::DW,
  parameter int AW = outbuf_drain_pkg::AW
);
  logic          EN_O;
  logic          RW_O;
  logic [AW-1:0] ADDR_O;
  logic [DW-1:0] RDATA_O;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_LAST;

  modport master (
    output EN_O, RW_O, ADDR_O, OUT_VALID, OUT_DATA, OUT_LAST,
    input  RDATA_O, OUT_READY
  );

  modport slave (
    input  EN_O, RW_O, ADDR_O, OUT_VALID, OUT_DATA, OUT_LAST,
    output RDATA_O, OUT_READY
  );
endinterface

// File: rtl/outbuf_fifo.sv
// Skid FIFO for returning SRAM words; head visible combinationally, push/pop same edge.
// Push while full is accepted only when a pop frees the slot in the same cycle.
module outbuf_fifo #(
  parameter int  DW     = 64,
  parameter int  FDEPTH = 2,
  localparam int PW     = (FDEPTH > 1) ? $clog2(FDEPTH) : 1,
  localparam int CW     = $clog2(FDEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] head_dat,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [FDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(FDEPTH)) || do_pop);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FDEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/outbuf_drain.sv
// Drains packed results from the output SRAM to a valid/ready stream: first word 3 cycles
// after START, then 1 word/cycle; reads are credit-limited so the skid FIFO never overflows.
module outbuf_drain #(
  parameter int DW     = outbuf_drain_pkg::DW,
  parameter int AW     = outbuf_drain_pkg::AW,
  parameter int FDEPTH = 2
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic [11:0]        MNT,
  input  logic               START,
  output logic               BUSY,
  output logic               DONE,
  outbuf_drain_if.master     bus
);
  import outbuf_drain_pkg::*;

  localparam int CW  = $clog2(FDEPTH + 1);
  localparam int WCW = AW + 1;

  state_t         state_q;
  state_t         state_d;
  logic [WCW-1:0] wcnt_q;
  logic [WCW-1:0] rd_addr_q;
  logic [WCW-1:0] sent_q;
  logic           inflight_q;
  logic [CW-1:0]  fifo_count;
  logic [DW-1:0]  head_dat;
  logic [CW:0]    credit_use;
  logic           issue;
  logic           pop;
  logic           out_vld;
  logic           out_last;

  assign out_vld  = (fifo_count != '0);
  assign pop      = out_vld && bus.OUT_READY;
  assign out_last = out_vld && (sent_q == wcnt_q - 1'b1);

  // Occupancy after this cycle, counting the read already on its way back from SRAM.
  assign credit_use = (CW+1)'(fifo_count) + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue      = (state_q == RUN) && (rd_addr_q < wcnt_q) &&
                      (credit_use < (CW+1)'(FDEPTH));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (START) state_d = (word_count(MNT) == 8'd0) ? FIN : RUN;
      RUN:     if (pop && out_last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wcnt_q     <= '0;
      rd_addr_q  <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if ((state_q == IDLE) && START) begin
        wcnt_q    <= WCW'(word_count(MNT));
        rd_addr_q <= '0;
        sent_q    <= '0;
      end else begin
        if (issue) rd_addr_q <= rd_addr_q + 1'b1;
        if (pop)   sent_q    <= sent_q + 1'b1;
      end
    end
  end

  outbuf_fifo #(.DW(DW), .FDEPTH(FDEPTH)) u_fifo (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .push     (inflight_q),
    .push_dat (bus.RDATA_O),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (fifo_count)
  );

  assign BUSY          = (state_q == RUN);
  assign DONE          = (state_q == FIN);
  assign bus.EN_O      = issue;
  assign bus.RW_O      = 1'b0;
  assign bus.ADDR_O    = issue ? rd_addr_q[AW-1:0] : '0;
  assign bus.OUT_VALID = out_vld;
  assign bus.OUT_DATA  = head_dat;
  assign bus.OUT_LAST  = out_last;

endmodule

// File: tb/tb_outbuf_drain.sv
// Directed bench for outbuf_drain: SRAM model with one-cycle read latency and
// hand-computed cycle timing, word order, backpressure and reset-abort expectations.
module tb_outbuf_drain;
  localparam int FDEPTH = 2;

  logic        CLK   = 1'b0;
  logic        RSTN  = 1'b0;
  logic        START = 1'b0;
  logic [11:0] MNT   = 12'h000;
  logic        BUSY;
  logic        DONE;

  outbuf_drain_if bus ();

  outbuf_drain #(.DW(64), .AW(4), .FDEPTH(FDEPTH)) dut (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .MNT   (MNT),
    .START (START),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  logic [63:0] sram [16];
  int vectors = 0;
  int errors  = 0;

  function automatic logic [63:0] word(input int i);
    return 64'h1111_0000_0000_0000 * 64'(i) + 64'(i);
  endfunction

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                         bus.RDATA_O <= '0;
    else if (bus.EN_O && !bus.RW_O)    bus.RDATA_O <= sram[bus.ADDR_O];
  end

  // Results of the last drain() run, recorded by observation only.
  int c_en, c_words, c_max_addr, c_order_bad, c_data_bad, c_hold_bad;
  int c_credit_bad, c_rw_bad, c_last_idx, c_nlast, c_done, c_done_cyc;

  task automatic drain(input logic [11:0] mnt, input bit stall, input int limit);
    int          exp_addr = 0;
    int          issued   = 0;
    int          popped   = 0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_dat = '0;
    logic        prev_last = 1'b0;
    c_en = 0; c_words = 0; c_max_addr = -1; c_order_bad = 0; c_data_bad = 0;
    c_hold_bad = 0; c_credit_bad = 0; c_rw_bad = 0; c_last_idx = -1; c_nlast = 0;
    c_done = 0; c_done_cyc = -1;
    @(posedge CLK); #1;
    MNT = mnt; START = 1'b1; bus.OUT_READY = 1'b1;
    for (int c = 0; c < limit; c++) begin
      @(negedge CLK);
      if (bus.RW_O) c_rw_bad++;
      if (bus.EN_O) begin
        if (int'(bus.ADDR_O) != exp_addr) c_order_bad++;
        if (int'(bus.ADDR_O) > c_max_addr) c_max_addr = int'(bus.ADDR_O);
        exp_addr++; issued++; c_en++;
      end
      if (prev_stall && (!bus.OUT_VALID || bus.OUT_DATA !== prev_dat || bus.OUT_LAST !== prev_last))
        c_hold_bad++;
      if (bus.OUT_VALID && bus.OUT_READY) begin
        if (bus.OUT_DATA !== word(c_words)) c_data_bad++;
        if (bus.OUT_LAST) begin c_last_idx = c_words; c_nlast++; end
        c_words++; popped++;
      end
      if (issued - popped > FDEPTH) c_credit_bad++;
      prev_stall = bus.OUT_VALID && !bus.OUT_READY;
      prev_dat   = bus.OUT_DATA;
      prev_last  = bus.OUT_LAST;
      if (DONE) begin c_done++; c_done_cyc = c; break; end
      @(posedge CLK); #1;
      START = 1'b0;
      bus.OUT_READY = stall ? ((c + 1) % 3 == 0) : 1'b1;
    end
    @(posedge CLK); #1;
    START = 1'b0; bus.OUT_READY = 1'b1;
  endtask

  task automatic test_reset();
    logic [73:0] obs;
    bus.OUT_READY = 1'b1;
    repeat (2) @(negedge CLK);
    obs = {BUSY, DONE, bus.EN_O, bus.RW_O, bus.ADDR_O, bus.OUT_VALID, bus.OUT_LAST, bus.OUT_DATA};
    vectors++;
    if (obs !== 74'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", obs); end
    @(posedge CLK); #1; RSTN = 1'b1;
  endtask

  task automatic test_basic();
    logic [9:0] obs, exp;
    @(posedge CLK); #1;
    MNT = 12'h404; START = 1'b1; bus.OUT_READY = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge CLK);
      exp = {(c >= 1 && c <= 6), (c == 7), (c >= 1 && c <= 4), 1'b0,
             (c >= 1 && c <= 4) ? 4'(c - 1) : 4'd0, (c >= 3 && c <= 6), (c == 6)};
      obs = {BUSY, DONE, bus.EN_O, bus.RW_O, bus.ADDR_O, bus.OUT_VALID, bus.OUT_LAST};
      vectors++;
      if (obs !== exp) begin errors++; $display("FAIL basic_ctl cyc%0d: got %b want %b", c, obs, exp); end
      if (c >= 3 && c <= 6) begin
        vectors++;
        if (bus.OUT_DATA !== word(c - 3))
          begin errors++; $display("FAIL basic_data cyc%0d: got %h want %h", c, bus.OUT_DATA, word(c - 3)); end
      end
      @(posedge CLK); #1; START = 1'b0;
    end
  endtask

  task automatic test_wcnt3();
    drain(12'h3F3, 1'b0, 60);
    vectors++; if (c_en !== 3)        begin errors++; $display("FAIL wcnt3_reads: got %0d want 3", c_en); end
    vectors++; if (c_max_addr !== 2)  begin errors++; $display("FAIL wcnt3_maxaddr: got %0d want 2", c_max_addr); end
    vectors++; if (c_order_bad !== 0) begin errors++; $display("FAIL wcnt3_order: got %0d want 0", c_order_bad); end
    vectors++; if (c_words !== 3 || c_data_bad !== 0)
      begin errors++; $display("FAIL wcnt3_words: got %0d/%0d bad want 3/0", c_words, c_data_bad); end
    vectors++; if (c_last_idx !== 2 || c_nlast !== 1)
      begin errors++; $display("FAIL wcnt3_last: got idx %0d n %0d want 2 1", c_last_idx, c_nlast); end
    vectors++; if (c_done_cyc !== 6)  begin errors++; $display("FAIL wcnt3_done_cycle: got %0d want 6", c_done_cyc); end
  endtask

  task automatic test_saturate();
    drain(12'hF01, 1'b0, 60);
    vectors++; if (c_en !== 16 || c_words !== 16)
      begin errors++; $display("FAIL sat_count: got %0d reads %0d words want 16 16", c_en, c_words); end
    vectors++; if (c_done_cyc !== 19) begin errors++; $display("FAIL sat_done_cycle: got %0d want 19", c_done_cyc); end
  endtask

  task automatic test_backpressure();
    drain(12'h808, 1'b1, 300);
    vectors++; if (c_words !== 16)     begin errors++; $display("FAIL bp_words: got %0d want 16", c_words); end
    vectors++; if (c_en !== 16)        begin errors++; $display("FAIL bp_reads: got %0d want 16", c_en); end
    vectors++; if (c_max_addr !== 15 || c_order_bad !== 0)
      begin errors++; $display("FAIL bp_addr: got max %0d bad %0d want 15 0", c_max_addr, c_order_bad); end
    vectors++; if (c_data_bad !== 0)   begin errors++; $display("FAIL bp_data: got %0d bad want 0", c_data_bad); end
    vectors++; if (c_hold_bad !== 0)   begin errors++; $display("FAIL bp_hold: got %0d bad want 0", c_hold_bad); end
    vectors++; if (c_credit_bad !== 0) begin errors++; $display("FAIL bp_credit: got %0d bad want 0", c_credit_bad); end
    vectors++; if (c_last_idx !== 15 || c_nlast !== 1)
      begin errors++; $display("FAIL bp_last: got idx %0d n %0d want 15 1", c_last_idx, c_nlast); end
    vectors++; if (c_done !== 1 || c_rw_bad !== 0)
      begin errors++; $display("FAIL bp_done_rw: got done %0d rw %0d want 1 0", c_done, c_rw_bad); end
  endtask

  task automatic test_zero();
    logic [4:0] obs, exp;
    @(posedge CLK); #1;
    MNT = 12'h000; START = 1'b1; bus.OUT_READY = 1'b1;
    for (int c = 0; c <= 2; c++) begin
      @(negedge CLK);
      exp = {1'b0, (c == 1), 3'b000};
      obs = {BUSY, DONE, bus.EN_O, bus.OUT_VALID, bus.OUT_LAST};
      vectors++;
      if (obs !== exp) begin errors++; $display("FAIL zero_cyc%0d: got %b want %b", c, obs, exp); end
      @(posedge CLK); #1; START = 1'b0;
    end
  endtask

  task automatic test_restart_and_reset();
    logic [2:0]  obs3;
    logic [73:0] obs;
    @(posedge CLK); #1;
    MNT = 12'h808; START = 1'b1; bus.OUT_READY = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge CLK);
      if (c >= 3) begin
        obs3 = {BUSY, bus.OUT_VALID, bus.OUT_LAST};
        vectors++;
        if (obs3 !== 3'b110 || bus.OUT_DATA !== word(c - 3))
          begin errors++; $display("FAIL restart_word%0d: got %b %h want 110 %h", c - 3, obs3, bus.OUT_DATA, word(c - 3)); end
      end
      if (c == 8) break;
      @(posedge CLK); #1;
      START = (c == 1);
      MNT   = (c == 1) ? 12'h101 : 12'h808;
    end
    #1 RSTN = 1'b0;
    #1;
    obs = {BUSY, DONE, bus.EN_O, bus.RW_O, bus.ADDR_O, bus.OUT_VALID, bus.OUT_LAST, bus.OUT_DATA};
    vectors++;
    if (obs !== 74'd0) begin errors++; $display("FAIL abort_outputs: got %h want 0", obs); end
    @(posedge CLK); #1; RSTN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      vectors++;
      if ({BUSY, DONE, bus.EN_O, bus.OUT_VALID} !== 4'b0000)
        begin errors++; $display("FAIL abort_quiet cyc%0d: got %b want 0000", c, {BUSY, DONE, bus.EN_O, bus.OUT_VALID}); end
    end
    drain(12'h206, 1'b0, 60);
    vectors++; if (c_en !== 3 || c_order_bad !== 0)
      begin errors++; $display("FAIL fresh_reads: got %0d bad %0d want 3 0", c_en, c_order_bad); end
    vectors++; if (c_words !== 3 || c_data_bad !== 0 || c_last_idx !== 2)
      begin errors++; $display("FAIL fresh_words: got %0d bad %0d last %0d want 3 0 2", c_words, c_data_bad, c_last_idx); end
    vectors++; if (c_done_cyc !== 6)   begin errors++; $display("FAIL fresh_done_cycle: got %0d want 6", c_done_cyc); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) sram[i] = word(i);
    bus.OUT_READY = 1'b1;
    test_reset();
    test_basic();
    test_wcnt3();
    test_saturate();
    test_backpressure();
    test_zero();
    test_restart_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
